eth_rx_axis: RTL and testbench

Receive-direction bridge from the RMII receiver byte stream to an AXI Stream master. It is the counterpart of the AXIS-slave transmit path.
- Buffers each incoming frame in a byte RAM and evaluates it at frame end.
- Commits frames with good CRC and legal length; rolls back runt, giant, bad-CRC and overflowing frames.
- Replays committed frames on AXIS with tlast on the final byte, optionally stripping the 4-byte FCS.
- Sits between eth_rx (Eth_Clk domain) and the host-facing AXIS port.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/eth_rx_frame_fifo.sv | 44 ++++
 rtl/eth_rx_axis.sv | 205 ++++++++++++++++++++
 tb/tb_eth_rx_axis.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, FSM encodings and helpers for the Ethernet receive path.
package eth_pkg;

  localparam int ETH_MIN_FRAME = 64;
  localparam int ETH_MAX_FRAME = 1518;
  localparam int ETH_FCS_BYTES = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RECV = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_SEND  = 2'd2
  } rd_state_t;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_frame_fifo.sv
// Synchronous FIFO of committed frame end pointers, written by the receive
// side at commit time and popped by the AXIS side after tlast.
module eth_rx_frame_fifo #(
  parameter int WIDTH = 12,
  parameter int LOG2  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [0:(1<<LOG2)-1];
  logic [LOG2:0]    wr_ptr;
  logic [LOG2:0]    rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                 (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign dout  = mem[rd_ptr[LOG2-1:0]];

  // Storage array write port.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[LOG2-1:0]] <= din;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  // NOTE: sequential state is always assigned with <= so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/eth_rx_axis.sv
// Receive bridge: buffers RMII receiver frames in a byte RAM, commits good
// frames, rolls back bad ones, and replays committed frames as AXI Stream.
module eth_rx_axis
  import eth_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11,
  parameter int FRM_LOG2   = 3,
  parameter int STRIP_FCS  = 1
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic [7:0]  Rx_Byte,
  input  logic        Rx_Byte_Valid,
  input  logic        Rx_Pkt_End,
  input  logic        Crc_Valid,
  output logic [7:0]  AXIS_Master_tdata,
  output logic        AXIS_Master_tvalid,
  output logic        AXIS_Master_tlast,
  input  logic        AXIS_Slave_tready,
  output logic [15:0] Pkt_Good_Cnt,
  output logic [15:0] Pkt_Drop_Cnt
);

  localparam int AW = DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] RAM_BYTES = PW'(2**AW);
  localparam logic [PW-1:0] FCS_TRIM  = PW'((STRIP_FCS != 0) ? ETH_FCS_BYTES : 0);
  localparam logic [10:0]   LEN_MAX   = 11'd2047;

  // ---------------- data RAM ----------------
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] ram_q;

  // ---------------- write side ----------------
  wr_state_t     w_state, w_next;
  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] commit_ptr, commit_n;
  logic [PW-1:0] frame_end;
  logic [10:0]   len, len_n;
  logic          mem_we;
  logic          push;
  logic          good_inc, drop_inc;
  logic          ram_full;

  // ---------------- read side ----------------
  rd_state_t     r_state, r_next;
  logic [PW-1:0] rd_ptr, rd_ptr_n;
  logic [PW-1:0] end_ptr, end_n;
  logic          pop;
  logic          last_byte;

  // ---------------- frame FIFO ----------------
  logic [PW-1:0] fifo_dout;
  logic          fifo_full, fifo_empty;

  assign ram_full = ((wr_ptr - rd_ptr) == RAM_BYTES);

  eth_rx_frame_fifo #(
    .WIDTH (PW),
    .LOG2  (FRM_LOG2)
  ) u_frame_fifo (
    .clk   (Clk),
    .rst_n (Rstn),
    .push  (push),
    .pop   (pop),
    .din   (frame_end),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write FSM next-state: store bytes, then commit or roll back at frame end.
  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    w_next    = w_state;
    wr_ptr_n  = wr_ptr;
    commit_n  = commit_ptr;
    len_n     = len;
    mem_we    = 1'b0;
    push      = 1'b0;
    good_inc  = 1'b0;
    drop_inc  = 1'b0;
    frame_end = wr_ptr;
    unique case (w_state)
      W_IDLE: begin
        if (Rx_Byte_Valid) begin
          if (fifo_full || ram_full) begin
            w_next = W_DROP;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            len_n    = 11'd1;
            w_next   = W_RECV;
          end
        end
      end
      W_RECV: begin
        if (Rx_Byte_Valid) begin
          if (ram_full) begin
            w_next   = W_DROP;
            wr_ptr_n = commit_ptr;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            len_n    = (len == LEN_MAX) ? len : len + 11'd1;
          end
        end
      end
      default: ;
    endcase
    // Frame end is evaluated after this cycle's byte has been accounted for.
    if (Rx_Pkt_End) begin
      if (w_next == W_DROP) begin
        drop_inc = 1'b1;
        wr_ptr_n = commit_ptr;
        w_next   = W_IDLE;
      end else if (w_next == W_RECV) begin
        if (Crc_Valid && len_n >= 11'(ETH_MIN_FRAME) && len_n <= 11'(ETH_MAX_FRAME)) begin
          frame_end = wr_ptr_n - FCS_TRIM;
          push      = 1'b1;
          commit_n  = frame_end;
          wr_ptr_n  = frame_end;
          good_inc  = 1'b1;
        end else begin
          wr_ptr_n = commit_ptr;
          drop_inc = 1'b1;
        end
        w_next = W_IDLE;
      end
    end
  end

  // Write FSM state, pointers, length and statistics counters.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      w_state      <= W_IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      len          <= '0;
      Pkt_Good_Cnt <= '0;
      Pkt_Drop_Cnt <= '0;
    end else begin
      w_state    <= w_next;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_n;
      len        <= len_n;
      if (good_inc) Pkt_Good_Cnt <= sat_inc16(Pkt_Good_Cnt);
      if (drop_inc) Pkt_Drop_Cnt <= sat_inc16(Pkt_Drop_Cnt);
    end
  end

  // Simple dual-port RAM; the read address tracks the next rd_ptr so ram_q
  // always holds the byte at rd_ptr and stays put while the sink stalls.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= Rx_Byte;
    ram_q <= mem[rd_ptr_n[AW-1:0]];
  end

  assign last_byte = ((rd_ptr + 1'b1) == end_ptr);

  // Read FSM next-state: fetch the head frame and stream it byte by byte.
  always_comb begin
    r_next   = r_state;
    rd_ptr_n = rd_ptr;
    end_n    = end_ptr;
    pop      = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (!fifo_empty) begin
          end_n  = fifo_dout;
          r_next = R_FETCH;
        end
      end
      R_FETCH: r_next = R_SEND;
      R_SEND: begin
        if (AXIS_Slave_tready) begin
          rd_ptr_n = rd_ptr + 1'b1;
          if (last_byte) begin
            pop    = 1'b1;
            r_next = R_IDLE;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM state and pointers.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      r_state <= R_IDLE;
      rd_ptr  <= '0;
      end_ptr <= '0;
    end else begin
      r_state <= r_next;
      rd_ptr  <= rd_ptr_n;
      end_ptr <= end_n;
    end
  end

  assign AXIS_Master_tvalid = (r_state == R_SEND);
  assign AXIS_Master_tdata  = AXIS_Master_tvalid ? ram_q : 8'h00;
  assign AXIS_Master_tlast  = AXIS_Master_tvalid && last_byte;

endmodule

// File: tb/tb_eth_rx_axis.sv
// Scoreboard bench for eth_rx_axis: stimulus pushes expected AXIS beats,
// an independent monitor pops and compares on every handshake.
module tb_eth_rx_axis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        rx_end = 1'b0;
  logic        crc_ok = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b0;
  logic [15:0] good_cnt;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 1;          // 0: held low, 1: held high, 2: toggling
  logic [8:0] exp_q[$];        // {tlast, tdata}

  eth_rx_axis #(
    .DEPTH_LOG2 (11),
    .FRM_LOG2   (3),
    .STRIP_FCS  (1)
  ) dut (
    .Clk                (clk),
    .Rstn               (rst_n),
    .Rx_Byte            (rx_byte),
    .Rx_Byte_Valid      (rx_valid),
    .Rx_Pkt_End         (rx_end),
    .Crc_Valid          (crc_ok),
    .AXIS_Master_tdata  (tdata),
    .AXIS_Master_tvalid (tvalid),
    .AXIS_Master_tlast  (tlast),
    .AXIS_Slave_tready  (tready),
    .Pkt_Good_Cnt       (good_cnt),
    .Pkt_Drop_Cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats of a committed frame: all but the 4 FCS bytes.
  task automatic expect_frame(input int len, input int seed);
    for (int i = 0; i < len - 4; i++) begin
      logic [7:0] b;
      b = 8'(seed + i);
      exp_q.push_back({(i == len - 5), b});
    end
  endtask

  // Drives one frame; Rx_Pkt_End either on the last byte or one cycle later.
  task automatic send_frame(input int len, input int seed, input logic crc, input logic sep_end);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      rx_byte  = 8'(seed + i);
      rx_valid = 1'b1;
      rx_end   = !sep_end && (i == len - 1);
      crc_ok   = crc;
    end
    if (sep_end) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_end   = 1'b1;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_end   = 1'b0;
    crc_ok   = 1'b0;
  endtask

  // Waits (bounded) for the scoreboard to empty, then a few quiet cycles.
  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drained_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // tready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = ~tready;
      endcase
    end
  end

  // Monitor: compares each handshake against the scoreboard and checks
  // that a stalled beat stays valid and unchanged.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", 32'(tvalid), 32'd1);
          check("stall_hold", 32'({tlast, tdata}), 32'(prev_word));
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got last=%0b data=%0h expected no beat", tlast, tdata);
          end else begin
            check("axis_beat", 32'({tlast, tdata}), 32'(exp_q.pop_front()));
          end
        end
        prev_stall = tvalid && !tready;
        prev_word  = {tlast, tdata};
      end
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_good", 32'(good_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: minimum good frame, FCS stripped.
    ready_mode = 1;
    expect_frame(64, 8'h10);
    send_frame(64, 8'h10, 1'b1, 1'b0);
    drain("t1", 400);
    check("t1_good", 32'(good_cnt), 32'd1);
    check("t1_drop", 32'(drop_cnt), 32'd0);

    // 2: bad CRC frame, then a good frame with separate end pulse.
    send_frame(100, 8'h80, 1'b0, 1'b0);
    expect_frame(64, 8'h33);
    send_frame(64, 8'h33, 1'b1, 1'b1);
    drain("t2", 400);
    check("t2_good", 32'(good_cnt), 32'd2);
    check("t2_drop", 32'(drop_cnt), 32'd1);

    // 3: runt and giant, both with good CRC.
    send_frame(63, 8'h01, 1'b1, 1'b0);
    send_frame(1519, 8'h02, 1'b1, 1'b0);
    drain("t3", 50);
    check("t3_good", 32'(good_cnt), 32'd2);
    check("t3_drop", 32'(drop_cnt), 32'd3);
    check("t3_tvalid", 32'(tvalid), 32'd0);

    // 4: toggling tready.
    ready_mode = 2;
    expect_frame(64, 8'hC0);
    send_frame(64, 8'hC0, 1'b1, 1'b0);
    drain("t4", 600);
    check("t4_good", 32'(good_cnt), 32'd3);

    // 5: 2100 bytes with the sink stalled; the third frame overflows.
    ready_mode = 0;
    expect_frame(1000, 8'h05);
    expect_frame(1000, 8'h77);
    send_frame(1000, 8'h05, 1'b1, 1'b0);
    send_frame(1000, 8'h77, 1'b1, 1'b0);
    send_frame(100, 8'hE0, 1'b1, 1'b0);
    check("t5_good", 32'(good_cnt), 32'd5);
    check("t5_drop", 32'(drop_cnt), 32'd4);
    ready_mode = 1;
    drain("t5", 4000);
    expect_frame(64, 8'h44);
    send_frame(64, 8'h44, 1'b1, 1'b0);
    drain("t5b", 400);
    check("t5_good_after", 32'(good_cnt), 32'd6);

    // 6: reset mid-stream (read side) and mid-frame (write side).
    ready_mode = 2;
    expect_frame(64, 8'h90);
    send_frame(64, 8'h90, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      rx_byte  = 8'(8'hA0 + i);
      rx_valid = 1'b1;
    end
    @(posedge clk); #2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_tvalid", 32'(tvalid), 32'd0);
    check("t6_rst_tdata", 32'(tdata), 32'd0);
    check("t6_rst_tlast", 32'(tlast), 32'd0);
    check("t6_rst_good", 32'(good_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_mode = 1;
    expect_frame(70, 8'h5A);
    send_frame(70, 8'h5A, 1'b1, 1'b0);
    drain("t6", 400);
    check("t6_good", 32'(good_cnt), 32'd1);
    check("t6_drop", 32'(drop_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
